// File: rtl/trng_pkg.sv
// Shared constants and types for the ring-oscillator TRNG post-processing slice.
package trng_pkg;

    // Default build-time parameters of the harvester.
    localparam int DEF_N          = 30;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_SAMPLE_DIV = 4;
    localparam int DEF_REP_LIMIT  = 32;
    localparam int DEF_DEPTH      = 4;

    // Width of the saturating dropped-word counter.
    localparam int DROP_W = 16;

    // Von Neumann corrector states: waiting for the first or the second bit of a pair.
    typedef enum logic {
        IDLE       = 1'b0,
        HAVE_FIRST = 1'b1
    } vn_state_t;

    // A von Neumann pair yields a bit only when its two samples differ.
    function automatic logic vn_pair_emits(input logic first_bit, input logic second_bit);
        return first_bit ^ second_bit;
    endfunction

endpackage

// File: rtl/trng_fifo.sv
// Synchronous show-ahead FIFO: the head word is presented whenever the FIFO is not empty.
// DEPTH must be a power of two and at least 2. Flush has priority over push and pop.
module trng_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    // Pointer wrap bit distinguishes full from empty when the index bits match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Head word, forced to zero while empty so stale storage never leaks out.
    always_comb begin
        rdata = {WIDTH{1'b0}};
        if (!empty) begin
            rdata = r_mem[r_rd_ptr[AW-1:0]];
        end else begin
            rdata = {WIDTH{1'b0}};
        end
    end

    // Storage and pointer update; flush simply rewinds both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= wdata;
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/trng_harvester.sv
// TRNG post-processing: synchronise and XOR-fold the ring oscillators, decimate,
// von Neumann debias, repetition-count health test, pack into words and buffer.
module trng_harvester
    import trng_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int REP_LIMIT  = DEF_REP_LIMIT,
    parameter int DEPTH      = DEF_DEPTH
)(
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [N-1:0]      RO_IN,
    input  logic              EN,
    output logic [WIDTH-1:0]  RND_DATA,
    output logic              RND_VALID,
    input  logic              RND_READY,
    output logic              HEALTH_FAIL,
    output logic [DROP_W-1:0] DROP_CNT
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // XOR fold of all oscillator bits into a single raw bit.
    function automatic logic fold_bits(input logic [N-1:0] v);
        return ^v;
    endfunction

    logic [N-1:0]      r_s1;
    logic [N-1:0]      r_s2;
    logic              r_raw;
    logic [DIV_W-1:0]  r_div_cnt;
    vn_state_t         r_vn_state;
    logic              r_first;
    logic [WIDTH-2:0]  r_word;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_last;
    logic              r_health_fail;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_strobe;
    logic [REP_W-1:0]  w_rep_next;
    logic              w_trip;
    logic              w_emit;
    logic              w_bit;
    logic [WIDTH-1:0]  w_word_next;
    logic              w_word_done;
    logic              w_hold;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [WIDTH-1:0]  w_fifo_data;

    assign w_strobe = EN && (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // Two-flop synchroniser on every oscillator, then fold to one raw bit per cycle.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_s1  <= {N{1'b0}};
            r_s2  <= {N{1'b0}};
            r_raw <= 1'b0;
        end else begin
            r_s1  <= RO_IN;
            r_s2  <= r_s1;
            r_raw <= fold_bits(r_s2);
        end
    end

    // Decimation counter: advances only while enabled, wraps on the sample strobe.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_div_cnt <= {DIV_W{1'b0}};
        end else if (w_strobe) begin
            r_div_cnt <= {DIV_W{1'b0}};
        end else if (EN) begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end else begin
            r_div_cnt <= r_div_cnt;
        end
    end

    // Repetition-count next value and the trip condition on reaching the limit.
    always_comb begin
        w_rep_next = r_rep_cnt;
        w_trip     = 1'b0;
        if (w_strobe && !r_health_fail) begin
            if ((r_rep_cnt == {REP_W{1'b0}}) || (r_raw != r_last)) begin
                w_rep_next = REP_W'(1);
            end else if (r_rep_cnt < REP_W'(REP_LIMIT)) begin
                w_rep_next = r_rep_cnt + REP_W'(1);
            end else begin
                w_rep_next = r_rep_cnt;
            end
            w_trip = (w_rep_next == REP_W'(REP_LIMIT));
        end else begin
            w_rep_next = r_rep_cnt;
            w_trip     = 1'b0;
        end
    end

    // Health test state; the failure flag is sticky until the asynchronous reset.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_rep_cnt     <= {REP_W{1'b0}};
            r_last        <= 1'b0;
            r_health_fail <= 1'b0;
        end else begin
            r_rep_cnt <= w_rep_next;
            if (w_strobe && !r_health_fail) begin
                r_last <= r_raw;
            end else begin
                r_last <= r_last;
            end
            if (w_trip) begin
                r_health_fail <= 1'b1;
            end else begin
                r_health_fail <= r_health_fail;
            end
        end
    end

    // Corrector output bit, packer word completion and FIFO handshake terms.
    always_comb begin
        w_emit = 1'b0;
        w_bit  = 1'b0;
        if (w_strobe && (r_vn_state == HAVE_FIRST) && vn_pair_emits(r_first, r_raw)) begin
            w_emit = 1'b1;
            w_bit  = r_first;
        end else begin
            w_emit = 1'b0;
            w_bit  = 1'b0;
        end
    end

    assign w_word_next = {r_word, w_bit};
    assign w_word_done = w_emit && (r_bit_cnt == CNT_W'(WIDTH - 1));
    // The trip edge already counts as failed so nothing is pushed or dropped there.
    assign w_hold      = r_health_fail || w_trip;
    assign w_push      = w_word_done && !w_hold;
    assign w_pop       = !w_empty && RND_READY;

    // Von Neumann pair FSM and MSB-first bit packer, both cleared while failed.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_vn_state <= IDLE;
            r_first    <= 1'b0;
            r_word     <= {(WIDTH-1){1'b0}};
            r_bit_cnt  <= {CNT_W{1'b0}};
        end else if (w_hold) begin
            r_vn_state <= IDLE;
            r_first    <= 1'b0;
            r_word     <= {(WIDTH-1){1'b0}};
            r_bit_cnt  <= {CNT_W{1'b0}};
        end else if (w_strobe) begin
            case (r_vn_state)
                IDLE: begin
                    r_first    <= r_raw;
                    r_vn_state <= HAVE_FIRST;
                end
                HAVE_FIRST: begin
                    r_vn_state <= IDLE;
                end
                default: begin
                    r_vn_state <= IDLE;
                end
            endcase
            if (w_emit) begin
                r_word <= w_word_next[WIDTH-2:0];
                if (w_word_done) begin
                    r_bit_cnt <= {CNT_W{1'b0}};
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end else begin
                r_word    <= r_word;
                r_bit_cnt <= r_bit_cnt;
            end
        end else begin
            r_vn_state <= r_vn_state;
            r_first    <= r_first;
            r_word     <= r_word;
            r_bit_cnt  <= r_bit_cnt;
        end
    end

    // Saturating count of completed words discarded because the FIFO was full.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_drop_cnt <= {DROP_W{1'b0}};
        end else if (w_push && w_full && !w_pop && (r_drop_cnt != {DROP_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    trng_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_hold),
        .wdata (w_word_next),
        .rdata (w_fifo_data),
        .full  (w_full),
        .empty (w_empty)
    );

    assign RND_DATA    = w_fifo_data;
    assign RND_VALID   = !w_empty;
    assign HEALTH_FAIL = r_health_fail;
    assign DROP_CNT    = r_drop_cnt;

endmodule
